multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control FSM for the 16-bit RISCBlade core. It sequences the shared ProgramCounter, ALU and MEMORY datapath through fetch, decode, execute, memory and writeback steps, producing every enable and mux select from the current opcode and the ALU zero flag. It sits beside the datapath and owns no data values; it also keeps a sticky illegal-opcode flag and a retired-instruction counter.

## Interface
- INSTR_CNT_W, 16, width of retired-instruction counter
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-high
- opcode  in  4  instruction register bits [15:12]
- zero  in  1  ALU ZERO flag
- mem_ready  in  1  memory done; used only under MEM_WAIT_EN
- pc_en  out  1  PC loads next address
- pc_src  out  2  0 ALU out, 1 ALU-result register (branch target), 2 jump target
- ir_write  out  1  latch MEM_OUT into IR
- mem_addr_sel  out  1  0 PC, 1 ALU-result register
- mem_write  out  1  MEMORY MEMWRITE
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  0 reg B, 1 constant 2, 2 sign-ext imm, 3 imm<<1
- alu_op  out  2  0 add, 1 sub, 2 and, 3 or
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file controls
- halted  out  1  core stopped
- illegal  out  1  sticky, undefined opcode seen
- instr_count  out  INSTR_CNT_W  retired instructions, wraps

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 JMP, F HALT; A–E illegal.
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, HALT.
- RESET: all outputs 0; next FETCH.
- FETCH: mem_addr_sel 0, ir_write 1, alu_src_a 0, alu_src_b 1, alu_op add, pc_src 0, pc_en 1 (PC+2). Next DECODE.
- DECODE: ALU computes PC + imm<<1 into ALU-result register. Next: 0–3 EXEC_R, 4 EXEC_I, 5/6 MEM_ADDR, 7/8 BRANCH, 9 JUMP, F HALT, A–E set illegal and go FETCH (NOP).
- EXEC_R: alu_src_a 1, alu_src_b 0, alu_op = opcode[1:0]; next ALU_WB.
- EXEC_I: alu_src_a 1, alu_src_b 2, add; next ALU_WB.
- ALU_WB: reg_write 1, reg_dst = 1 for R-type, mem_to_reg 0; retire; next FETCH.
- MEM_ADDR: A + sign-ext imm; next MEM_READ (LW) or MEM_WR (SW).
- MEM_READ: mem_addr_sel 1; next MEM_WB. MEM_WB: reg_write 1, mem_to_reg 1; retire; next FETCH.
- MEM_WR: mem_addr_sel 1, mem_write 1; retire; next FETCH.
- BRANCH: alu sub A-B, pc_src 1, pc_en = zero (BEQ) or ~zero (BNE); retire; next FETCH.
- JUMP: pc_src 2, pc_en 1; retire; next FETCH.
- HALT: halted 1, all enables 0; remains until reset; HALT itself not counted.
- Retire = instr_count + 1 at the clock edge leaving the retiring state; wraps from all-ones to 0.

## Timing
- Outputs are Moore decodes of registered state, except BRANCH pc_en (combinational on zero) and MEM_WAIT_EN gating.
- Cycles: BRANCH/JUMP 3, R/ADDI/SW 4, LW 5; first FETCH one cycle after reset release.
- Reset mid-instruction: state RESET, illegal 0, instr_count 0 asynchronously; no partial write completes.
- Illegal opcode: illegal set at DECODE edge, not counted.

## Configuration
- MULTICYCLE_CONTROL_MEM_WAIT_EN defined: FETCH, MEM_READ, MEM_WR hold while mem_ready = 0; in FETCH pc_en/ir_write assert only when mem_ready = 1; mem_write stays high through MEM_WR wait cycles.
- Undefined: mem_ready ignored; every memory state lasts exactly one cycle.

## Structure
- Package riscblade_ctrl_pkg: opcode constants, state enum, alu_op codes, pc_src/alu_src_b/mem_addr_sel encodings.
- One sub-module natural: ctrl_output_decode (state, opcode, zero, mem_ready -> control outputs); FSM, illegal flag and counter stay in top.

## Test plan
- Reset held, then released -> all outputs 0 in RESET; FETCH next cycle with pc_en 1, alu_src_b 1, ir_write 1.
- opcode 0 (ADD) -> FETCH, DECODE, EXEC_R (alu_op 0), ALU_WB (reg_write 1, reg_dst 1); instr_count 0 -> 1 after 4 cycles.
- opcode 5 (LW) then 6 (SW) -> 5 then 4 cycles; mem_to_reg 1 in MEM_WB; mem_write 1 only in MEM_WR.
- BEQ with zero 1 -> pc_en 1, pc_src 1 in BRANCH; BNE with zero 1 -> pc_en 0; both increment count.
- opcode B -> illegal 1, back to FETCH, count unchanged; opcode F -> halted 1 indefinitely until reset clears it.
- MEM_WAIT_EN, mem_ready low 3 cycles during FETCH -> FETCH held 4 cycles, pc_en pulses once.

Source files
------------

// File: rtl/riscblade_ctrl_pkg.sv
// Shared encodings for the RISCBlade multicycle controller: opcodes, FSM states, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscblade_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR, ST_MEM_READ,
    ST_MEM_WB, ST_MEM_WR, ST_ALU_WB, ST_BRANCH, ST_JUMP, ST_HALT
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_TWO    = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic MEM_ADDR_PC     = 1'b0;
  localparam logic MEM_ADDR_ALUOUT = 1'b1;

  // Opcodes A..E are unassigned and treated as NOPs that raise the sticky flag.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Decodes FSM state (+opcode, zero, mem_ready) into every datapath enable and mux select.
// Latency: purely combinational.
// Backpressure: with MULTICYCLE_CONTROL_MEM_WAIT_EN, FETCH pc_en/ir_write wait for mem_ready.
module ctrl_output_decode
  import riscblade_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_addr_sel,
  output logic       mem_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted
);

  state_t st;
  assign st = state_t'(state);

  logic fetch_go;
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  assign fetch_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign fetch_go = 1'b1;
`endif

  // Moore decode per state; only BRANCH pc_en looks at the live zero flag.
  always_comb begin
    pc_en        = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_write     = 1'b0;
    mem_addr_sel = MEM_ADDR_PC;
    mem_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRC_B_REG;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    halted       = 1'b0;
    case (st)
      ST_FETCH: begin
        alu_src_b = SRC_B_TWO;
        pc_en     = fetch_go;
        ir_write  = fetch_go;
      end
      ST_DECODE:   alu_src_b = SRC_B_IMM_SH;
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = opcode[1:0];
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      ST_MEM_READ: mem_addr_sel = MEM_ADDR_ALUOUT;
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_addr_sel = MEM_ADDR_ALUOUT;
        mem_write    = 1'b1;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode[3:2] == 2'b00);
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_en     = (opcode == OP_BEQ) ? zero : ~zero;
      end
      ST_JUMP: begin
        pc_src = PC_SRC_JUMP;
        pc_en  = 1'b1;
      end
      ST_HALT:     halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// RISCBlade multicycle control FSM with sticky illegal flag and retired-instruction counter.
// Latency: BRANCH/JUMP 3, R/ADDI/SW 4, LW 5 cycles; first FETCH one cycle after reset release.
// Backpressure: MULTICYCLE_CONTROL_MEM_WAIT_EN holds FETCH/MEM_READ/MEM_WR until mem_ready.
module multicycle_control
  import riscblade_ctrl_pkg::*;
#(
  parameter int INSTR_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic [1:0]             pc_src,
  output logic                   ir_write,
  output logic                   mem_addr_sel,
  output logic                   mem_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   halted,
  output logic                   illegal,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  state_t                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [INSTR_CNT_W-1:0] instr_count_q, instr_count_d;
  logic                   retire;
  logic                   mem_hold;

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
  assign mem_hold = ~mem_ready;
`else
  assign mem_hold = 1'b0;
`endif

  // Next-state, retire strobe and illegal-opcode capture.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  if (!mem_hold) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_EXEC_R;
          OP_ADDI:                       state_d = ST_EXEC_I;
          OP_LW, OP_SW:                  state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                state_d = ST_BRANCH;
          OP_JMP:                        state_d = ST_JUMP;
          OP_HALT:                       state_d = ST_HALT;
          default: begin
            illegal_d = is_illegal_op(opcode) | illegal_q;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
      ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WR;
      ST_MEM_READ: if (!mem_hold) state_d = ST_MEM_WB;
      ST_MEM_WR: begin
        if (!mem_hold) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_RESET;
    endcase
    instr_count_d = retire ? instr_count_q + 1'b1 : instr_count_q;
  end

  // State, flag and counter registers; reset clears all of them immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RESET;
      illegal_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      illegal_q     <= illegal_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign illegal     = illegal_q;
  assign instr_count = instr_count_q;

  ctrl_output_decode u_decode (
    .state        (state_q),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .mem_addr_sel (mem_addr_sel),
    .mem_write    (mem_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .halted       (halted)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle control words from a queue, table of instructions.
// Latency: n/a.
// Backpressure: mem_ready stalls in FETCH exercised (effective with MULTICYCLE_CONTROL_MEM_WAIT_EN).
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = 4'h0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          pc_en, ir_write, mem_addr_sel, mem_write, alu_src_a;
  logic          reg_write, reg_dst, mem_to_reg, halted, illegal;
  logic [1:0]    pc_src, alu_src_b, alu_op;
  logic [CW-1:0] instr_count;

  multicycle_control #(.INSTR_CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write), .mem_addr_sel(mem_addr_sel),
    .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // {pc_en, pc_src, ir_write, mem_addr_sel, mem_write, alu_src_a, alu_src_b, alu_op,
  //  reg_write, reg_dst, mem_to_reg, halted}
  logic [14:0] act;
  assign act = {pc_en, pc_src, ir_write, mem_addr_sel, mem_write, alu_src_a, alu_src_b,
                alu_op, reg_write, reg_dst, mem_to_reg, halted};

  function automatic logic [14:0] mk(input logic pe, input logic [1:0] ps, input logic ir,
                                     input logic mas, input logic mw, input logic a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic rw, input logic rd, input logic mtr,
                                     input logic h);
    return {pe, ps, ir, mas, mw, a, b, op, rw, rd, mtr, h};
  endfunction

  int total = 0;
  int bad   = 0;
  logic [14:0]   exp_q[$];
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_ill = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected control words for one instruction, written from the opcode table.
  task automatic push_expected(input logic [3:0] op, input logic z, input int wf, input int nh);
    logic [14:0] fetch_w, dec_w;
    fetch_w = mk(1, 0, 1, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0);
    dec_w   = mk(0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 0, 0, 0, 0);
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    for (int i = 0; i < wf; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0));
`else
    if (wf < 0) exp_q.push_back(fetch_w);
`endif
    exp_q.push_back(fetch_w);
    exp_q.push_back(dec_w);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'd0, op[1:0], 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 0, 0));
      end
      4'h4: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0));
      end
      4'h5: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 0));
      end
      4'h6: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0));
      end
      4'h7: exp_q.push_back(mk(z, 2'd1, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0, 0, 0));
      4'h8: exp_q.push_back(mk(~z, 2'd1, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0, 0, 0));
      4'h9: exp_q.push_back(mk(1, 2'd2, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0));
      4'hF: for (int i = 0; i < nh; i++)
              exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1));
      default: ;
    endcase
  endtask

  // Drive one instruction, compare every cycle's word, then the counter and flag.
  task automatic run_instr(input logic [3:0] op, input logic z, input int wf, input int nh,
                           input int inc, input logic ill);
    int step = 0;
    push_expected(op, z, wf, nh);
    while (exp_q.size() > 0) begin
      logic [14:0] e;
      @(negedge clock);
      opcode    = op;
      zero      = z;
      mem_ready = (step < wf) ? 1'b0 : 1'b1;
      #1;
      e = exp_q.pop_front();
      check($sformatf("ctrl op%0h step%0d", op, step), {17'd0, act}, {17'd0, e});
      step++;
    end
    mem_ready = 1'b1;
    @(posedge clock);
    #1;
    exp_cnt = exp_cnt + inc[CW-1:0];
    exp_ill = exp_ill | ill;
    check($sformatf("count op%0h", op), {28'd0, instr_count}, {28'd0, exp_cnt});
    check($sformatf("illegal op%0h", op), {31'd0, illegal}, {31'd0, exp_ill});
  endtask

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         wf;
    int         inc;
    logic       ill;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'h0, 1'b0, 0, 1, 1'b0};
    vecs[1]  = '{4'h1, 1'b0, 0, 1, 1'b0};
    vecs[2]  = '{4'h2, 1'b1, 0, 1, 1'b0};
    vecs[3]  = '{4'h3, 1'b0, 0, 1, 1'b0};
    vecs[4]  = '{4'h4, 1'b0, 0, 1, 1'b0};
    vecs[5]  = '{4'h5, 1'b0, 0, 1, 1'b0};
    vecs[6]  = '{4'h6, 1'b0, 0, 1, 1'b0};
    vecs[7]  = '{4'h7, 1'b1, 0, 1, 1'b0};
    vecs[8]  = '{4'h7, 1'b0, 0, 1, 1'b0};
    vecs[9]  = '{4'h8, 1'b1, 0, 1, 1'b0};
    vecs[10] = '{4'h8, 1'b0, 0, 1, 1'b0};
    vecs[11] = '{4'h9, 1'b0, 0, 1, 1'b0};
    vecs[12] = '{4'hB, 1'b0, 0, 0, 1'b1};
    vecs[13] = '{4'h0, 1'b0, 3, 1, 1'b0};
    vecs[14] = '{4'hA, 1'b0, 0, 0, 1'b1};
    vecs[15] = '{4'hE, 1'b1, 0, 0, 1'b1};
    vecs[16] = '{4'h5, 1'b0, 2, 1, 1'b0};
    vecs[17] = '{4'h6, 1'b1, 1, 1, 1'b0};

    // Reset held, then released: RESET outputs all zero until the first edge.
    repeat (2) @(negedge clock);
    #1;
    check("reset ctrl", {17'd0, act}, 32'd0);
    check("reset count", {28'd0, instr_count}, 32'd0);
    check("reset illegal", {31'd0, illegal}, 32'd0);
    reset = 1'b0;
    #1;
    check("reset state after release", {17'd0, act}, 32'd0);

    for (int i = 0; i < 18; i++)
      run_instr(vecs[i].op, vecs[i].z, vecs[i].wf, 0, vecs[i].inc, vecs[i].ill);

    // Counter wraps from all-ones back to zero.
    for (int i = 0; i < 20; i++) run_instr(4'h9, 1'b0, 0, 0, 1, 1'b0);

    // HALT holds indefinitely and is not counted.
    run_instr(4'hF, 1'b0, 0, 6, 0, 1'b0);

    // Asynchronous reset from HALT clears flag, counter and outputs at once.
    @(negedge clock);
    reset = 1'b1;
    #1;
    exp_cnt = '0;
    exp_ill = 1'b0;
    check("async reset ctrl", {17'd0, act}, 32'd0);
    check("async reset count", {28'd0, instr_count}, 32'd0);
    check("async reset illegal", {31'd0, illegal}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Reset during ALU_WB: the retire and register write never complete.
    opcode = 4'h0;
    repeat (4) @(negedge clock);
    #1;
    check("mid ALU_WB reg_write", {31'd0, reg_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset reg_write", {31'd0, reg_write}, 32'd0);
    @(posedge clock);
    #1;
    check("mid reset count", {28'd0, instr_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_instr(4'h0, 1'b0, 0, 0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
